// File: rtl/tick_ctrl_pkg.sv
// tick_ctrl shared types and defaults.
// Optional strobe outputs: define TICK_CTRL_STROBE_EN.
package tick_ctrl_pkg;

  localparam int TC_W     = 8;
  localparam int TC_DIV_A = 4;
  localparam int TC_DIV_B = 49;

  localparam logic CH_A = 1'b0;
  localparam logic CH_B = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PEND,
    ST_DONE
  } cfg_state_e;

endpackage

// File: rtl/tick_chan.sv
// One divided-clock channel: divisor, counter, output level.
// Strobe output present only with TICK_CTRL_STROBE_EN.
module tick_chan
  import tick_ctrl_pkg::*;
#(
  parameter int W       = TC_W,
  parameter int DEF_DIV = TC_DIV_A
) (
  input  logic         clock1M,
  input  logic         reset,
  input  logic         run_en,
  input  logic         load,
  input  logic [W-1:0] load_div,
  output logic         safe,
`ifdef TICK_CTRL_STROBE_EN
  output logic         tick,
`endif
  output logic         clk_out
);

  logic [W-1:0] div_q;
  logic [W-1:0] cnt_q;
  logic         clk_q;
  logic         halted;
  logic         term;
  logic         halt_load;

  assign halted    = (div_q == '0);
  assign term      = run_en && !halted && (cnt_q == div_q);
  assign safe      = !run_en || halted || (cnt_q == div_q);
  assign halt_load = load && (load_div == '0);
  assign clk_out   = clk_q;

  // A load in a terminal-count cycle still toggles with the old divisor.
  always_ff @(posedge clock1M) begin
    if (!reset) begin
      div_q <= W'(DEF_DIV);
      cnt_q <= '0;
      clk_q <= 1'b0;
    end else begin
      if (term) begin
        clk_q <= ~clk_q;
        cnt_q <= '0;
      end else if (run_en && !halted) begin
        cnt_q <= cnt_q + W'(1);
      end
      if (load) begin
        div_q <= load_div;
        cnt_q <= '0;
        if (halt_load) begin
          clk_q <= 1'b0;
        end
      end
    end
  end

`ifdef TICK_CTRL_STROBE_EN
  logic tick_q;

  assign tick = tick_q;

  always_ff @(posedge clock1M) begin
    if (!reset) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= term && !halt_load;
    end
  end
`endif

endmodule

// File: rtl/tick_ctrl.sv
// Two-channel tick divider with handshaked reconfiguration.
// Optional tick_a/tick_b strobes: define TICK_CTRL_STROBE_EN.
module tick_ctrl
  import tick_ctrl_pkg::*;
#(
  parameter int W         = TC_W,
  parameter int DEF_DIV_A = TC_DIV_A,
  parameter int DEF_DIV_B = TC_DIV_B
) (
  input  logic         clock1M,
  input  logic         reset,
  input  logic         run_en,
  input  logic         cfg_valid,
  input  logic         cfg_sel,
  input  logic [W-1:0] cfg_div,
  output logic         cfg_ready,
  output logic         cfg_done,
`ifdef TICK_CTRL_STROBE_EN
  output logic         tick_a,
  output logic         tick_b,
`endif
  output logic         clk_a,
  output logic         clk_b
);

  cfg_state_e   state_q;
  cfg_state_e   state_d;
  logic         sel_q;
  logic [W-1:0] pdiv_q;
  logic         safe_a;
  logic         safe_b;
  logic         tgt_safe;
  logic         load_a;
  logic         load_b;

  always_ff @(posedge clock1M) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      sel_q   <= CH_A;
      pdiv_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && cfg_valid) begin
        sel_q  <= cfg_sel;
        pdiv_q <= cfg_div;
      end
    end
  end

  always_comb begin
    tgt_safe = safe_a;
    unique case (1'b1)
      (sel_q == CH_B): tgt_safe = safe_b;
      default:         tgt_safe = safe_a;
    endcase
  end

  // Requests arriving outside IDLE are dropped, not queued.
  always_comb begin
    state_d   = state_q;
    load_a    = 1'b0;
    load_b    = 1'b0;
    cfg_ready = 1'b0;
    cfg_done  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          state_d = ST_PEND;
        end
      end
      ST_PEND: begin
        if (tgt_safe) begin
          load_a  = (sel_q == CH_A);
          load_b  = (sel_q == CH_B);
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        cfg_done = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  tick_chan #(
    .W       (W),
    .DEF_DIV (DEF_DIV_A)
  ) u_chan_a (
    .clock1M  (clock1M),
    .reset    (reset),
    .run_en   (run_en),
    .load     (load_a),
    .load_div (pdiv_q),
    .safe     (safe_a),
`ifdef TICK_CTRL_STROBE_EN
    .tick     (tick_a),
`endif
    .clk_out  (clk_a)
  );

  tick_chan #(
    .W       (W),
    .DEF_DIV (DEF_DIV_B)
  ) u_chan_b (
    .clock1M  (clock1M),
    .reset    (reset),
    .run_en   (run_en),
    .load     (load_b),
    .load_div (pdiv_q),
    .safe     (safe_b),
`ifdef TICK_CTRL_STROBE_EN
    .tick     (tick_b),
`endif
    .clk_out  (clk_b)
  );

endmodule

// File: tb/tb_tick_ctrl.sv
// Scoreboard bench for tick_ctrl against a half-period reference model.
// Strobe checks compiled in with TICK_CTRL_STROBE_EN.
module tb_tick_ctrl;

  localparam int W = 8;

  logic         clock1M = 1'b0;
  logic         reset = 1'b0;
  logic         run_en = 1'b0;
  logic         cfg_valid = 1'b0;
  logic         cfg_sel = 1'b0;
  logic [W-1:0] cfg_div = '0;
  logic         cfg_ready;
  logic         cfg_done;
  logic         clk_a;
  logic         clk_b;
`ifdef TICK_CTRL_STROBE_EN
  logic         tick_a;
  logic         tick_b;
`endif

  tick_ctrl #(
    .W         (W),
    .DEF_DIV_A (4),
    .DEF_DIV_B (49)
  ) dut (
    .clock1M   (clock1M),
    .reset     (reset),
    .run_en    (run_en),
    .cfg_valid (cfg_valid),
    .cfg_sel   (cfg_sel),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .cfg_done  (cfg_done),
`ifdef TICK_CTRL_STROBE_EN
    .tick_a    (tick_a),
    .tick_b    (tick_b),
`endif
    .clk_a     (clk_a),
    .clk_b     (clk_b)
  );

  always #5 clock1M = ~clock1M;

  typedef struct packed {
    logic ca;
    logic cb;
    logic rdy;
    logic done;
    logic ta;
    logic tb;
  } exp_t;

  exp_t expq[$];
  int   total = 0;
  int   bad = 0;

  // Model: each channel waits rem more active cycles, then flips.
  int   m_div[2];
  int   m_rem[2];
  bit   m_lvl[2];
  int   m_st;
  int   m_psel;
  int   m_pdiv;

  task automatic model_step(input bit rst, input bit run,
                            input bit cv, input bit sel,
                            input int dv);
    exp_t e;
    bit   tg[2];
    bit   safe;
    e  = '0;
    tg = '{1'b0, 1'b0};
    if (!rst) begin
      m_div = '{4, 49};
      m_rem = '{4, 49};
      m_lvl = '{1'b0, 1'b0};
      m_st  = 0;
    end else begin
      safe = 1'b0;
      if (m_st == 1) begin
        safe = !run || (m_div[m_psel] == 0) || (m_rem[m_psel] == 0);
      end
      for (int ch = 0; ch < 2; ch++) begin
        if (run && m_div[ch] != 0) begin
          if (m_rem[ch] == 0) begin
            tg[ch]    = 1'b1;
            m_lvl[ch] = !m_lvl[ch];
            m_rem[ch] = m_div[ch];
          end else begin
            m_rem[ch] = m_rem[ch] - 1;
          end
        end
      end
      case (m_st)
        0: if (cv) begin
          m_st   = 1;
          m_psel = sel ? 1 : 0;
          m_pdiv = dv;
        end
        1: if (safe) begin
          m_div[m_psel] = m_pdiv;
          m_rem[m_psel] = m_pdiv;
          if (m_pdiv == 0) begin
            m_lvl[m_psel] = 1'b0;
            tg[m_psel]    = 1'b0;
          end
          m_st = 2;
        end
        default: m_st = 0;
      endcase
    end
    e.ca   = m_lvl[0];
    e.cb   = m_lvl[1];
    e.rdy  = (m_st == 0);
    e.done = (m_st == 2);
    e.ta   = tg[0];
    e.tb   = tg[1];
    expq.push_back(e);
  endtask

  task automatic cyc(input bit rst, input bit run, input bit cv,
                     input bit sel, input int dv);
    reset     = rst;
    run_en    = run;
    cfg_valid = cv;
    cfg_sel   = sel;
    cfg_div   = W'(dv);
    model_step(rst, run, cv, sel, dv);
    @(posedge clock1M);
    #2;
  endtask

  task automatic idle(input int n, input bit run);
    for (int i = 0; i < n; i++) cyc(1'b1, run, 1'b0, 1'b0, 0);
  endtask

  task automatic chk(input string name, input logic act,
                     input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at %0t: got %b want %b",
               name, $time, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock1M);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("clk_a", clk_a, e.ca);
        chk("clk_b", clk_b, e.cb);
        chk("cfg_ready", cfg_ready, e.rdy);
        chk("cfg_done", cfg_done, e.done);
`ifdef TICK_CTRL_STROBE_EN
        chk("tick_a", tick_a, e.ta);
        chk("tick_b", tick_b, e.tb);
`endif
      end
    end
  end

  initial begin : stim
    bit rst;
    bit run;
    bit cv;
    bit sel;
    int dv;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 1'b1, 0);
    idle(220, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 0);
    idle(2, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 9);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 3);
    idle(80, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 0);
    idle(60, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1);
    idle(30, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 7);
    idle(6, 1'b0);
    idle(70, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 30);
    idle(2, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 0);
    idle(30, 1'b1);
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 399) != 0);
      run = ($urandom_range(0, 9) != 0);
      cv  = ($urandom_range(0, 4) == 0);
      sel = $urandom_range(0, 1) != 0;
      dv  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 12);
      cyc(rst, run, cv, sel, dv);
    end
    idle(4, 1'b1);
    chk("queue_drained", expq.size() == 0, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tick_ctrl.md
TICK_CTRL -- requirements
Module: tick_ctrl

Interface
REQ-001 Parameter W, default 8: divisor and counter width.
REQ-002 Parameter DEF_DIV_A, default 4: channel A reset divisor (100 kHz from 1 MHz).
REQ-003 Parameter DEF_DIV_B, default 49: channel B reset divisor (10 kHz from 1 MHz).
REQ-004 clock1M  input  1  system clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 run_en  input  1  high: channels count; low: counters and outputs freeze.
REQ-007 cfg_valid  input  1  reconfiguration request.
REQ-008 cfg_sel  input  1  target channel, 0=A, 1=B.
REQ-009 cfg_div  input  W  new divisor; 0 halts the channel.
REQ-010 cfg_ready  output  1  controller can accept a request.
REQ-011 cfg_done  output  1  one-cycle pulse when a request has been applied.
REQ-012 clk_a, clk_b  output  1  divided square outputs.
REQ-013 tick_a, tick_b  output  1  one-cycle strobe per output toggle (macro-gated, REQ-032).

Function
REQ-014 Each channel SHALL hold div_x and cnt_x (W bits); with run_en=1 and div_x!=0: if cnt_x==div_x, clk_x toggles and cnt_x<=0, else cnt_x<=cnt_x+1.
REQ-015 Half-period SHALL be div_x+1 cycles; full period 2*(div_x+1).
REQ-016 tick_x SHALL be registered, high exactly in the cycle clk_x shows its new level.
REQ-017 div_x==0 SHALL hold clk_x low, cnt_x at 0, tick_x low.
REQ-018 run_en=0 SHALL freeze cnt_x and clk_x; tick_x low.
REQ-019 Controller FSM states: IDLE, PEND, DONE; cfg_ready=1 only in IDLE.
REQ-020 IDLE: cfg_valid=1 latches cfg_sel/cfg_div into pending registers, go to PEND.
REQ-021 PEND: apply when target is at a safe point (cnt==div with run_en=1, div==0, or run_en=0), then go to DONE.
REQ-022 Apply: div_x<=pending div, cnt_x<=0; a terminal-count toggle in the apply cycle still occurs using the old divisor.
REQ-023 Apply with new div 0 SHALL force clk_x low in the same cycle; apply from halted to nonzero starts with clk_x low, cnt_x=0.
REQ-024 DONE: cfg_done=1 for one cycle, return to IDLE; cfg_ready=1 in the following cycle.
REQ-025 cfg_valid outside IDLE SHALL be ignored, with no queuing.
REQ-026 The non-targeted channel SHALL never be disturbed by reconfiguration.
REQ-027 No glitch: clk_x changes only at terminal count, halt, or reset.

Reset
REQ-028 reset=0 at a clock edge: div_a=DEF_DIV_A, div_b=DEF_DIV_B, counters 0, clk_a=clk_b=0, tick_a=tick_b=0, cfg_done=0, FSM=IDLE, cfg_ready=1.
REQ-029 Reset mid-PEND SHALL discard the pending request with no cfg_done.
REQ-030 reset dominates run_en and cfg_valid.

Configuration
REQ-031 Macro TICK_CTRL_STROBE_EN.
REQ-032 Defined: tick_a/tick_b ports and logic exist per REQ-016. Undefined: ports and logic absent; all other behaviour identical.

Structure
REQ-033 Package tick_ctrl_pkg: W default, DEF_DIV_A/DEF_DIV_B defaults, FSM state enum, channel-select constants (CH_A=0, CH_B=1).
REQ-034 Sub-module tick_chan: one counter/divisor/output channel with load port and safe-point flag, instantiated twice.

Verification
REQ-035 Release reset, run_en=1 -> clk_a period 10 cycles, clk_b period 100 cycles, first clk_a rise 5 cycles after release.
REQ-036 In IDLE, cfg_valid, sel=0, div=9 while cnt_a=2 -> cfg_ready low next cycle; apply at cnt_a==4; cfg_done one cycle later; then clk_a period 20; clk_b unchanged.
REQ-037 cfg div=0 to B -> clk_b low at apply; then div=1 -> clk_b period 4, starting low.
REQ-038 run_en=0 with pending div=7 on A -> applies within 1 cycle, clk_a frozen; run_en=1 -> period 16.
REQ-039 reset=0 during PEND -> no cfg_done, divisors back to 4/49, cfg_ready=1.
REQ-040 Macro defined: tick_a pulses every 5 cycles at div 4, cfg_valid in PEND ignored; macro undefined: build passes, clk_a/clk_b waveforms unchanged.
